// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB scheduler.
// Holds the FSM state encoding, UART register offsets, status/control bit
// positions and small helpers that build APB addresses and control words.
package uart_apb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CFG_S   = 4'd1,
        ST_CFG_A   = 4'd2,
        ST_RX_S    = 4'd3,
        ST_RX_A    = 4'd4,
        ST_POLL_S  = 4'd5,
        ST_POLL_A  = 4'd6,
        ST_BACKOFF = 4'd7,
        ST_TX_S    = 4'd8,
        ST_TX_A    = 4'd9
    } state_e;

    localparam logic [7:0] UART_DATA_OFS = 8'h00;
    localparam logic [7:0] UART_STAT_OFS = 8'h04;

    localparam int STAT_RX_EMPTY = 0;
    localparam int STAT_TX_FULL  = 1;

    localparam int CTRL_BAUD_LSB = 0;
    localparam int CTRL_BAUD_W   = 2;
    localparam int CTRL_PAR_EN   = 2;

    function automatic logic [31:0] apb_addr(input logic [31:0] base, input logic [7:0] ofs);
        return base + {24'h000000, ofs};
    endfunction

    // Places {parity_en, baud_sel} into their control register fields.
    function automatic logic [31:0] ctrl_word(input logic [2:0] ctrl);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[CTRL_BAUD_LSB +: CTRL_BAUD_W] = ctrl[1:0];
        w[CTRL_PAR_EN]                  = ctrl[2];
        return w;
    endfunction

endpackage

// File: rtl/uart_apb_sched_if.sv
// APB bus bundle between the scheduler (master) and the UART (slave).
// master: drives psel/penable/pwrite/paddr/pwdata/pstrb/pprot,
//         receives prdata/pready/pslverr.
interface uart_apb_sched_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// req_i : request vector, ptr_i : highest-priority index this round.
// gnt_o : one-hot grant, idx_o : granted index, any_o : some request granted.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int PW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    // Search upward from ptr_i with wrap-around; first hit wins.
    always_comb begin
        logic [PW-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = PW'((int'(ptr_i) + i) % NREQ);
            if (req_i[cand] && !any_o) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                any_o       = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/uart_apb_sched.sv
// APB master sharing a console UART between NREQ transmit requesters,
// draining the UART receive FIFO into one output stream and issuing
// control-register writes.
// Ports: clock/reset (sync, active high); req_valid/req_data/req_ready
// transmit requesters; rx_valid/rx_data/rx_ready receive stream;
// cfg_wr/cfg_ctrl/cfg_busy configuration; uart_irq receive-not-empty;
// apb master bundle; err sticky slave-error flag.
module uart_apb_sched
    import uart_apb_pkg::*;
#(
    parameter int          NREQ     = 2,
    parameter logic [31:0] BASE     = 32'h0,
    parameter int          POLL_GAP = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rx_valid,
    output logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              cfg_wr,
    input  logic [2:0]        cfg_ctrl,
    output logic              cfg_busy,
    input  logic              uart_irq,
    uart_apb_sched_if.master  apb,
    output logic              err
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    state_e          state_q, state_d;
    logic            psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [31:0]     paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic            rx_valid_q, rx_valid_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            cfg_pend_q, cfg_pend_d;
    logic [2:0]      cfg_val_q, cfg_val_d;
    logic            err_q, err_d;
    logic [PW-1:0]   ptr_q, ptr_d, gidx_q, gidx_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0] req_eff_s, gnt_s;
    logic [PW-1:0]   gnt_idx_s;
    logic            gnt_any_s, apb_done_s;
    logic [7:0]      tx_byte_s;
    logic            unused_prdata_s;

    // A requester whose byte was accepted last cycle may still show valid
    // while it reacts to req_ready; masking it avoids a spurious re-poll.
    assign req_eff_s  = req_valid & ~req_ready_q;
    assign apb_done_s = apb.pready;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i (req_eff_s),
        .ptr_i (ptr_q),
        .gnt_o (gnt_s),
        .idx_o (gnt_idx_s),
        .any_o (gnt_any_s)
    );

    // Byte of the requester currently winning arbitration.
    always_comb begin
        tx_byte_s = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_s[i]) begin
                tx_byte_s = req_data[8*i +: 8];
            end else begin
                tx_byte_s = tx_byte_s;
            end
        end
    end

    // Next-state and registered-output computation for the APB sequencer.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        req_ready_d = '0;
        rx_data_d   = rx_data_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        cnt_d       = cnt_q;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        // A new pulse simply overwrites the latched value; one write results.
        if (cfg_wr) begin
            cfg_pend_d = 1'b1;
            cfg_val_d  = cfg_ctrl;
        end else begin
            cfg_pend_d = cfg_pend_q;
            cfg_val_d  = cfg_val_q;
        end

        if (psel_q && penable_q && apb.pready && apb.pslverr) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_pend_q) begin
                    state_d  = ST_CFG_S;
                    psel_d   = 1'b1;
                    pwrite_d = 1'b1;
                    paddr_d  = apb_addr(BASE, UART_STAT_OFS);
                    pwdata_d = ctrl_word(cfg_val_q);
                end else if (uart_irq && !rx_valid_q) begin
                    state_d  = ST_RX_S;
                    psel_d   = 1'b1;
                    pwrite_d = 1'b0;
                    paddr_d  = apb_addr(BASE, UART_DATA_OFS);
                    pwdata_d = 32'h0000_0000;
                end else if (|req_eff_s) begin
                    state_d  = ST_POLL_S;
                    psel_d   = 1'b1;
                    pwrite_d = 1'b0;
                    paddr_d  = apb_addr(BASE, UART_STAT_OFS);
                    pwdata_d = 32'h0000_0000;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CFG_S: begin
                state_d   = ST_CFG_A;
                penable_d = 1'b1;
            end
            ST_RX_S: begin
                state_d   = ST_RX_A;
                penable_d = 1'b1;
            end
            ST_POLL_S: begin
                state_d   = ST_POLL_A;
                penable_d = 1'b1;
            end
            ST_TX_S: begin
                state_d   = ST_TX_A;
                penable_d = 1'b1;
            end
            ST_CFG_A: begin
                if (apb_done_s) begin
                    state_d    = ST_IDLE;
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    // A pulse landing exactly on completion re-arms the write.
                    cfg_pend_d = cfg_wr;
                end else begin
                    state_d = ST_CFG_A;
                end
            end
            ST_RX_A: begin
                if (apb_done_s) begin
                    state_d    = ST_IDLE;
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    rx_data_d  = apb.prdata[7:0];
                    rx_valid_d = 1'b1;
                end else begin
                    state_d = ST_RX_A;
                end
            end
            ST_POLL_A: begin
                if (!apb_done_s) begin
                    state_d = ST_POLL_A;
                end else if (apb.prdata[STAT_TX_FULL]) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (POLL_GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BACKOFF;
                        cnt_d   = CW'(POLL_GAP);
                    end
                end else if (gnt_any_s) begin
                    // Status read ends and the data write's setup starts at once.
                    state_d   = ST_TX_S;
                    gidx_d    = gnt_idx_s;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b1;
                    paddr_d   = apb_addr(BASE, UART_DATA_OFS);
                    pwdata_d  = {24'h000000, tx_byte_s};
                end else begin
                    state_d   = ST_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end
            end
            ST_BACKOFF: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BACKOFF;
                end
            end
            ST_TX_A: begin
                if (apb_done_s) begin
                    state_d             = ST_IDLE;
                    psel_d              = 1'b0;
                    penable_d           = 1'b0;
                    req_ready_d[gidx_q] = 1'b1;
                    if (gidx_q == LAST_IDX) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gidx_q + PW'(1);
                    end
                end else begin
                    state_d = ST_TX_A;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'h0000_0000;
            pwdata_q    <= 32'h0000_0000;
            req_ready_q <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            cfg_pend_q  <= 1'b0;
            cfg_val_q   <= 3'b000;
            err_q       <= 1'b0;
            ptr_q       <= '0;
            gidx_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            req_ready_q <= req_ready_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            cfg_pend_q  <= cfg_pend_d;
            cfg_val_q   <= cfg_val_d;
            err_q       <= err_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            cnt_q       <= cnt_d;
        end
    end

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pstrb   = 4'b0001;
    assign apb.pprot   = 3'b000;
    assign req_ready   = req_ready_q;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign cfg_busy    = cfg_pend_q;
    assign err         = err_q;

    // Upper read-data bits and the rx_empty flag carry no meaning here.
    assign unused_prdata_s = ^{apb.prdata[31:8], apb.prdata[STAT_RX_EMPTY]};

endmodule

// File: tb/tb_uart_apb_sched.sv
module tb_uart_apb_sched;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [15:0] req_data = 16'h0000;
    logic [1:0]  req_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [2:0]  cfg_ctrl = 3'b000;
    logic        cfg_busy;
    logic        uart_irq = 1'b0;
    logic        err;

    uart_apb_sched_if apb ();

    uart_apb_sched #(.NREQ(2), .BASE(32'h0), .POLL_GAP(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .cfg_wr(cfg_wr), .cfg_ctrl(cfg_ctrl), .cfg_busy(cfg_busy),
        .uart_irq(uart_irq), .apb(apb), .err(err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // UART slave model and bus monitor
    logic [31:0] stat_q[$];
    logic [7:0]  rx_byte = 8'h00;
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    bit          err_data_wr = 1'b0;
    logic [31:0] log_addr[$];
    logic        log_wr[$];
    logic [31:0] log_wdata[$];
    int          gap_q[$];
    int          psel_cycles = 0;
    int          low_cnt = 0;
    int          rr_cnt0 = 0;
    int          rr_cnt1 = 0;
    int          rr_at_txn = 0;

    initial begin
        apb.prdata  = 32'h0;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
    end

    always @(posedge clock) begin
        #1;
        if (apb.psel) begin
            psel_cycles++;
            if (low_cnt > 0) gap_q.push_back(low_cnt);
            low_cnt = 0;
        end else begin
            low_cnt++;
        end
        if (req_ready[0]) begin rr_cnt0++; rr_at_txn = log_addr.size(); end
        if (req_ready[1]) begin rr_cnt1++; rr_at_txn = log_addr.size(); end
        if (apb.psel && !apb.penable) begin
            log_addr.push_back(apb.paddr);
            log_wr.push_back(apb.pwrite);
            log_wdata.push_back(apb.pwdata);
            wait_cnt = wait_cfg;
        end
        if (apb.psel && apb.penable) begin
            if (wait_cnt > 0) begin
                apb.pready  = 1'b0;
                apb.pslverr = 1'b0;
                wait_cnt--;
            end else begin
                apb.pready = 1'b1;
                if (apb.paddr == 32'h4) begin
                    if (stat_q.size() > 0) apb.prdata = stat_q.pop_front();
                    else apb.prdata = 32'h0;
                end else begin
                    apb.prdata = {24'h0, rx_byte};
                end
                apb.pslverr = err_data_wr && apb.pwrite && (apb.paddr == 32'h0);
            end
        end else begin
            apb.pready  = 1'b0;
            apb.pslverr = 1'b0;
            apb.prdata  = 32'h0;
        end
    end

    task automatic clear_logs();
        log_addr.delete(); log_wr.delete(); log_wdata.delete(); gap_q.delete();
        psel_cycles = 0; low_cnt = 0; rr_cnt0 = 0; rr_cnt1 = 0; rr_at_txn = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; req_valid = 2'b00; uart_irq = 1'b0; rx_ready = 1'b0; cfg_wr = 1'b0;
        stat_q.delete(); wait_cfg = 0; err_data_wr = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (apb.psel !== 1'b0) begin n_fail++; $display("FAIL reset_psel got %b want 0", apb.psel); end
        n_checks++; if (apb.penable !== 1'b0) begin n_fail++; $display("FAIL reset_penable got %b want 0", apb.penable); end
        n_checks++; if (apb.pwrite !== 1'b0) begin n_fail++; $display("FAIL reset_pwrite got %b want 0", apb.pwrite); end
        n_checks++; if (apb.paddr !== 32'h0) begin n_fail++; $display("FAIL reset_paddr got %h want 0", apb.paddr); end
        n_checks++; if (apb.pwdata !== 32'h0) begin n_fail++; $display("FAIL reset_pwdata got %h want 0", apb.pwdata); end
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        n_checks++; if ({rx_valid, cfg_busy, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {rx_valid, cfg_busy, err}); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        n_checks++; if (apb.pstrb !== 4'b0001 || apb.pprot !== 3'b000) begin n_fail++; $display("FAIL const_pstrb_pprot got %b/%b want 0001/000", apb.pstrb, apb.pprot); end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        stat_q.push_back(32'h1);
        req_data = 16'h0041; req_valid = 2'b01;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 100) begin @(negedge clock); n++; end
        req_valid = 2'b00;
        repeat (10) @(negedge clock);
        n_checks++; if (n >= 100) begin n_fail++; $display("FAIL single_timeout got %0d cycles want <100", n); end
        n_checks++; if (log_addr.size() != 2) begin n_fail++; $display("FAIL single_txn_count got %0d want 2", log_addr.size()); end
        if (log_addr.size() >= 2) begin
            n_checks++; if (log_addr[0] !== 32'h4 || log_wr[0] !== 1'b0) begin n_fail++; $display("FAIL single_poll got addr %h wr %b want 4/0", log_addr[0], log_wr[0]); end
            n_checks++; if (log_addr[1] !== 32'h0 || log_wr[1] !== 1'b1 || log_wdata[1] !== 32'h41) begin n_fail++; $display("FAIL single_write got %h/%b/%h want 0/1/41", log_addr[1], log_wr[1], log_wdata[1]); end
        end
        n_checks++; if (psel_cycles != 4) begin n_fail++; $display("FAIL single_psel_cycles got %0d want 4", psel_cycles); end
        n_checks++; if (rr_cnt0 != 1 || rr_cnt1 != 0) begin n_fail++; $display("FAIL single_req_ready got %0d/%0d want 1/0", rr_cnt0, rr_cnt1); end
    endtask

    task automatic test_back_to_back();
        int n, rem0, rem1, k;
        logic [7:0] exp_b[6];
        logic [7:0] got_b[$];
        exp_b = '{8'hAA, 8'hBB, 8'hAA, 8'hBB, 8'hAA, 8'hBB};
        do_reset();
        req_data = 16'hBBAA; req_valid = 2'b11; rem0 = 3; rem1 = 3; n = 0;
        while ((rem0 > 0 || rem1 > 0) && n < 400) begin
            @(negedge clock); n++;
            if (req_ready[0]) begin rem0--; if (rem0 == 0) req_valid[0] = 1'b0; end
            if (req_ready[1]) begin rem1--; if (rem1 == 0) req_valid[1] = 1'b0; end
        end
        req_valid = 2'b00;
        repeat (10) @(negedge clock);
        n_checks++; if (n >= 400) begin n_fail++; $display("FAIL b2b_timeout got %0d cycles want <400", n); end
        for (int i = 0; i < log_addr.size(); i++)
            if (log_wr[i] && log_addr[i] == 32'h0) got_b.push_back(log_wdata[i][7:0]);
        n_checks++; if (got_b.size() != 6) begin n_fail++; $display("FAIL b2b_write_count got %0d want 6", got_b.size()); end
        k = (got_b.size() < 6) ? got_b.size() : 6;
        for (int i = 0; i < k; i++) begin
            n_checks++; if (got_b[i] !== exp_b[i]) begin n_fail++; $display("FAIL b2b_byte%0d got %h want %h", i, got_b[i], exp_b[i]); end
        end
        n_checks++; if (rr_cnt0 != 3 || rr_cnt1 != 3) begin n_fail++; $display("FAIL b2b_req_ready got %0d/%0d want 3/3", rr_cnt0, rr_cnt1); end
    endtask

    task automatic test_backoff();
        int n;
        do_reset();
        stat_q.push_back(32'h2); stat_q.push_back(32'h2); stat_q.push_back(32'h0);
        req_data = 16'h0033; req_valid = 2'b01; n = 0;
        while (req_ready[0] !== 1'b1 && n < 200) begin @(negedge clock); n++; end
        req_valid = 2'b00;
        repeat (10) @(negedge clock);
        n_checks++; if (n >= 200) begin n_fail++; $display("FAIL backoff_timeout got %0d want <200", n); end
        n_checks++; if (log_addr.size() != 4) begin n_fail++; $display("FAIL backoff_txn_count got %0d want 4", log_addr.size()); end
        if (log_addr.size() == 4) begin
            n_checks++; if (log_addr[2] !== 32'h4 || log_addr[3] !== 32'h0 || log_wdata[3] !== 32'h33) begin n_fail++; $display("FAIL backoff_seq got %h/%h/%h want 4/0/33", log_addr[2], log_addr[3], log_wdata[3]); end
        end
        // psel low for 4 BACKOFF cycles plus the IDLE decision cycle
        n_checks++; if (gap_q.size() < 2 || gap_q[0] != 5 || gap_q[1] != 5) begin n_fail++; $display("FAIL backoff_gaps got n=%0d first=%0d want two gaps of 5", gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1); end
        n_checks++; if (rr_at_txn != 4 || rr_cnt0 != 1) begin n_fail++; $display("FAIL backoff_early_ready got txn=%0d cnt=%0d want 4/1", rr_at_txn, rr_cnt0); end
    endtask

    task automatic test_rx();
        int n;
        do_reset();
        rx_byte = 8'h5A; uart_irq = 1'b1; rx_ready = 1'b0;
        repeat (12) @(negedge clock);
        n_checks++; if (log_addr.size() != 1) begin n_fail++; $display("FAIL rx_single_read got %0d reads want 1", log_addr.size()); end
        n_checks++; if (log_addr.size() > 0 && (log_addr[0] !== 32'h0 || log_wr[0] !== 1'b0)) begin n_fail++; $display("FAIL rx_read_addr got %h/%b want 0/0", log_addr[0], log_wr[0]); end
        n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin n_fail++; $display("FAIL rx_hold got %b/%h want 1/5a", rx_valid, rx_data); end
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_accept got %b want 0", rx_valid); end
        n = 0;
        while (rx_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        n_checks++; if (log_addr.size() != 2 || rx_valid !== 1'b1) begin n_fail++; $display("FAIL rx_second_read got %0d reads valid %b want 2/1", log_addr.size(), rx_valid); end
        uart_irq = 1'b0; rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
    endtask

    task automatic test_cfg();
        int n;
        do_reset();
        wait_cfg = 3;
        req_data = 16'h0041; req_valid = 2'b01; n = 0;
        while (apb.psel !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        cfg_ctrl = 3'b101; cfg_wr = 1'b1;
        @(negedge clock);
        cfg_wr = 1'b0;
        n_checks++; if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL cfg_busy_set got %b want 1", cfg_busy); end
        n = 0;
        while (cfg_busy !== 1'b0 && n < 100) begin
            @(negedge clock); n++;
            if (req_ready[0]) req_valid[0] = 1'b0;
        end
        n_checks++; if (n >= 100) begin n_fail++; $display("FAIL cfg_timeout got %0d want <100", n); end
        n_checks++; if (log_addr.size() != 3 || apb.psel !== 1'b0) begin n_fail++; $display("FAIL cfg_busy_drop got txns=%0d psel=%b want 3/0", log_addr.size(), apb.psel); end
        if (log_addr.size() == 3) begin
            n_checks++; if (log_addr[1] !== 32'h0 || log_wdata[1] !== 32'h41) begin n_fail++; $display("FAIL cfg_tx_first got %h/%h want 0/41", log_addr[1], log_wdata[1]); end
            n_checks++; if (log_addr[2] !== 32'h4 || log_wr[2] !== 1'b1 || log_wdata[2] !== 32'h5) begin n_fail++; $display("FAIL cfg_write got %h/%b/%h want 4/1/5", log_addr[2], log_wr[2], log_wdata[2]); end
        end
        n_checks++; if (rr_cnt0 != 1) begin n_fail++; $display("FAIL cfg_req_ready got %0d want 1", rr_cnt0); end
        req_valid = 2'b00;
        wait_cfg = 0;
    endtask

    task automatic test_err_reset();
        int n;
        do_reset();
        err_data_wr = 1'b1;
        req_data = 16'h0041; req_valid = 2'b01; n = 0;
        while (req_ready[0] !== 1'b1 && n < 100) begin @(negedge clock); n++; end
        req_valid = 2'b00;
        n_checks++; if (n >= 100) begin n_fail++; $display("FAIL err_timeout got %0d want <100", n); end
        n_checks++; if (err !== 1'b1 || rr_cnt0 != 1) begin n_fail++; $display("FAIL err_set got err=%b rr=%0d want 1/1", err, rr_cnt0); end
        err_data_wr = 1'b0; wait_cfg = 6;
        @(negedge clock);
        req_data = 16'h0042; req_valid = 2'b01; n = 0;
        while (!(apb.psel && apb.penable && apb.pwrite) && n < 50) begin @(negedge clock); n++; end
        n_checks++; if (n >= 50) begin n_fail++; $display("FAIL err_access_timeout got %0d want <50", n); end
        cfg_ctrl = 3'b011; cfg_wr = 1'b1;
        @(negedge clock);
        cfg_wr = 1'b0; reset = 1'b1; req_valid = 2'b00;
        @(negedge clock);
        n_checks++; if ({apb.psel, apb.penable, apb.pwrite} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_ctrl got %b want 000", {apb.psel, apb.penable, apb.pwrite}); end
        n_checks++; if (apb.paddr !== 32'h0 || apb.pwdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_bus got %h/%h want 0/0", apb.paddr, apb.pwdata); end
        n_checks++; if ({req_ready, rx_valid, cfg_busy, err} !== 5'b0) begin n_fail++; $display("FAIL rst_mid_flags got %b want 00000", {req_ready, rx_valid, cfg_busy, err}); end
        reset = 1'b0; wait_cfg = 0;
        clear_logs();
        repeat (10) @(negedge clock);
        n_checks++; if (log_addr.size() != 0 || cfg_busy !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_discard got txns=%0d busy=%b want 0/0", log_addr.size(), cfg_busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backoff();
        test_rx();
        test_cfg();
        test_err_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
